z80_vdp99_core: RTL and testbench

// - TMS9918-style VDP CPU interface for the Z8S180 board: control latch, 8 write-only

---
 rtl/vdp99_pkg.sv | 31 +++
 rtl/vdp99_timing.sv | 55 +++++
 rtl/z80_vdp99_core.sv | 142 ++++++++++++++
 tb/tb_z80_vdp99_core.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp99_pkg.sv
// Shared constants for the VDP99 CPU interface: raster timing, register indices, R1 bits.
package vdp99_pkg;

  // Raster timing defaults, in phi clocks (horizontal) and lines (vertical)
  localparam int H_ACTIVE = 469;
  localparam int H_FP     = 12;
  localparam int H_SYNC   = 70;
  localparam int H_BP     = 35;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 586

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  // Register indices
  localparam logic [2:0] R_MODE0    = 3'd0;
  localparam logic [2:0] R_MODE1    = 3'd1;
  localparam logic [2:0] R_BACKDROP = 3'd7;

  // R1 bit positions
  localparam int BLANK = 6;
  localparam int IE    = 5;

  // The VRAM pointer is 14 bits and wraps 0x3FFF -> 0x0000
  function automatic logic [13:0] addr_inc(input logic [13:0] a);
    return a + 14'd1;
  endfunction

endpackage

// File: rtl/vdp99_timing.sv
// Raster timing generator: h/v counters, sync decode, visible flag, frame-start pulse.
// All decode outputs are combinational from the counters; the top registers them.
module vdp99_timing
  import vdp99_pkg::*;
#(
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
) (
  input  logic phi,
  input  logic reset,
  output logic visible,
  output logic hsync_n,
  output logic vsync_n,
  output logic frame_start
);

  localparam logic [9:0] H_VIS  = 10'(P_H_ACTIVE);
  localparam logic [9:0] HS_ON  = 10'(P_H_ACTIVE + P_H_FP);
  localparam logic [9:0] HS_OFF = 10'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
  localparam logic [9:0] H_LAST = 10'(P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP - 1);
  localparam logic [9:0] V_VIS  = 10'(P_V_ACTIVE);
  localparam logic [9:0] VS_ON  = 10'(P_V_ACTIVE + P_V_FP);
  localparam logic [9:0] VS_OFF = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC);
  localparam logic [9:0] V_LAST = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP - 1);

  logic [9:0] hcount;
  logic [9:0] vcount;

  // Pixel and line counters; vcount advances when hcount wraps
  always_ff @(posedge phi or negedge reset) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  assign visible     = (hcount < H_VIS) && (vcount < V_VIS);
  assign hsync_n     = !((hcount >= HS_ON) && (hcount < HS_OFF));
  // vcount only moves at hcount wrap, so vsync changes at line start
  assign vsync_n     = !((vcount >= VS_ON) && (vcount < VS_OFF));
  // First clock of the first blanked line
  assign frame_start = (hcount == 10'd0) && (vcount == V_VIS);

endmodule

// File: rtl/z80_vdp99_core.sv
// TMS9918-style CPU interface: control latch, R0..R7, 14-bit VRAM pointer,
// status flag F with irq, plus registered raster outputs (sync and backdrop colour).
module z80_vdp99_core
  import vdp99_pkg::*;
#(
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
) (
  input  logic       phi,
  input  logic       reset,
  input  logic       cpu_mode,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  output logic [3:0] color,
  output logic       hsync,
  output logic       vsync,
  output logic       irq
);

  logic        wr_reg;
  logic        rd_reg;
  logic        rd_mode_reg;
  logic        latch_flag_reg;
  logic [7:0]  latch_byte_reg;
  logic [13:0] addr_reg;
  logic        write_mode_reg;
  logic [7:0]  read_buf_reg;
  logic [7:0]  vreg [8];
  logic        f_reg;

  logic visible, hsync_n, vsync_n, frame_start;

  vdp99_timing #(
    .P_H_ACTIVE(P_H_ACTIVE), .P_H_FP(P_H_FP), .P_H_SYNC(P_H_SYNC), .P_H_BP(P_H_BP),
    .P_V_ACTIVE(P_V_ACTIVE), .P_V_FP(P_V_FP), .P_V_SYNC(P_V_SYNC), .P_V_BP(P_V_BP)
  ) u_timing (
    .phi         (phi),
    .reset       (reset),
    .visible     (visible),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .frame_start (frame_start)
  );

  // Actions fire on the edge where the registered strobe changes, so a held
  // strobe acts exactly once.
  logic wr_rise, rd_fall, ctrl_wr, data_wr, stat_rd, data_rd;
  assign wr_rise = cpu_wr & ~wr_reg;
  assign rd_fall = rd_reg & ~cpu_rd;
  assign ctrl_wr = wr_rise &  cpu_mode;
  assign data_wr = wr_rise & ~cpu_mode;
  // cpu_mode may already have moved when cpu_rd drops, so use the mode seen during the pulse
  assign stat_rd = rd_fall &  rd_mode_reg;
  assign data_rd = rd_fall & ~rd_mode_reg;

  // write_mode is consumed by the VRAM port outside this block
  logic unused_write_mode;
  assign unused_write_mode = write_mode_reg;

  // Strobe registers and the port select captured while a read is in progress
  always_ff @(posedge phi or negedge reset) begin
    if (!reset) begin
      wr_reg      <= 1'b0;
      rd_reg      <= 1'b0;
      rd_mode_reg <= 1'b0;
    end else begin
      wr_reg <= cpu_wr;
      rd_reg <= cpu_rd;
      if (cpu_rd) rd_mode_reg <= cpu_mode;
    end
  end

  // CPU protocol: two-byte control sequence, register writes, address pointer
  always_ff @(posedge phi or negedge reset) begin
    if (!reset) begin
      latch_flag_reg <= 1'b0;
      latch_byte_reg <= '0;
      addr_reg       <= '0;
      write_mode_reg <= 1'b0;
      read_buf_reg   <= '0;
      for (int i = 0; i < 8; i++) vreg[i] <= '0;
    end else if (ctrl_wr) begin
      if (!latch_flag_reg) begin
        latch_byte_reg <= cpu_din;
        latch_flag_reg <= 1'b1;
      end else begin
        latch_flag_reg <= 1'b0;
        if (cpu_din[7]) begin
          vreg[cpu_din[2:0]] <= latch_byte_reg;
        end else begin
          write_mode_reg <= cpu_din[6];
          if (cpu_din[6]) begin
            addr_reg <= {cpu_din[5:0], latch_byte_reg};
          end else begin
            // Read setup: prefetch (no VRAM here, so 0x00) and step past it
            addr_reg     <= addr_inc({cpu_din[5:0], latch_byte_reg});
            read_buf_reg <= 8'h00;
          end
        end
      end
    end else if (data_wr || data_rd) begin
      latch_flag_reg <= 1'b0;
      addr_reg       <= addr_inc(addr_reg);
    end else if (stat_rd) begin
      latch_flag_reg <= 1'b0;
    end
  end

  // Frame flag: a set in the same clock as a status-read clear wins
  always_ff @(posedge phi or negedge reset) begin
    if (!reset)           f_reg <= 1'b0;
    else if (frame_start) f_reg <= 1'b1;
    else if (stat_rd)     f_reg <= 1'b0;
  end

  // Registered outputs; cpu_dout is frozen while a read is in progress
  always_ff @(posedge phi or negedge reset) begin
    if (!reset) begin
      cpu_dout <= '0;
      irq      <= 1'b0;
      color    <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
    end else begin
      if (!rd_reg) cpu_dout <= cpu_mode ? {f_reg, 7'b0} : read_buf_reg;
      irq   <= f_reg & vreg[R_MODE1][IE];
      // Without pattern data, both enabled and blanked display show the backdrop
      color <= visible ? vreg[R_BACKDROP][3:0] : 4'h0;
      hsync <= hsync_n;
      vsync <= vsync_n;
    end
  end

endmodule

// File: tb/tb_z80_vdp99_core.sv
// Directed bench for z80_vdp99_core; vertical timing is shortened to keep frames short.
module tb_z80_vdp99_core;

  localparam int TB_VA  = 8;
  localparam int TB_VFP = 2;
  localparam int TB_VS  = 2;
  localparam int TB_VB  = 3;
  localparam int TB_VT  = TB_VA + TB_VFP + TB_VS + TB_VB;  // 15 lines
  localparam int H_TOT  = 586;

  logic       phi = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_mode = 1'b0;
  logic [7:0] cpu_din = 8'h00;
  logic       cpu_wr = 1'b0;
  logic       cpu_rd = 1'b0;
  logic [7:0] cpu_dout;
  logic [3:0] color;
  logic       hsync, vsync, irq;

  int checks = 0;
  int errors = 0;

  z80_vdp99_core #(
    .P_V_ACTIVE(TB_VA), .P_V_FP(TB_VFP), .P_V_SYNC(TB_VS), .P_V_BP(TB_VB)
  ) dut (
    .phi(phi), .reset(reset), .cpu_mode(cpu_mode), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .color(color), .hsync(hsync), .vsync(vsync), .irq(irq)
  );

  always #5 phi = ~phi;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge phi);
    #1;
  endtask

  task automatic bus_write(input logic mode, input logic [7:0] data, input int hold);
    $display("[tb] write %s 0x%02h", mode ? "ctrl" : "data", data);
    cpu_mode = mode;
    cpu_din  = data;
    cpu_wr   = 1'b1;
    tick(hold);
    cpu_wr = 1'b0;
    tick(2);
  endtask

  task automatic bus_read(input logic mode, output logic [7:0] seen);
    cpu_mode = mode;
    cpu_rd   = 1'b1;
    tick(3);
    seen   = cpu_dout;
    cpu_rd = 1'b0;
    tick(2);
    $display("[tb] read  %s -> 0x%02h", mode ? "stat" : "data", seen);
  endtask

  task automatic wait_pos(input int h, input int v);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 2 * TB_VT * H_TOT) begin
      tick(1);
      n++;
      if (dut.u_timing.hcount == 10'(h) && dut.u_timing.vcount == 10'(v)) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_pos: position (%0d,%0d) not reached within %0d clocks", h, v, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(4);
    $display("[tb] reset held 4 clocks");
    checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got 0x%02h want 0x00", cpu_dout); end
    checks++; if (irq !== 1'b0)       begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (hsync !== 1'b1)     begin errors++; $display("FAIL reset_hsync: got %b want 1", hsync); end
    checks++; if (vsync !== 1'b1)     begin errors++; $display("FAIL reset_vsync: got %b want 1", vsync); end
    checks++; if (color !== 4'h0)     begin errors++; $display("FAIL reset_color: got 0x%0h want 0x0", color); end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_registers();
    for (int i = 0; i < 8; i++) begin
      bus_write(1'b1, 8'(i), 3);
      bus_write(1'b1, 8'(8'h80 + i), 3);
      checks++;
      if (dut.vreg[i] !== 8'(i)) begin
        errors++; $display("FAIL reg_write R%0d: got 0x%02h want 0x%02h", i, dut.vreg[i], 8'(i));
      end
      checks++;
      if (dut.latch_flag_reg !== 1'b0) begin
        errors++; $display("FAIL reg_latch R%0d: got %b want 0", i, dut.latch_flag_reg);
      end
    end
    // color lags the counters by one clock
    wait_pos(100, 2);
    checks++; if (color !== 4'h7) begin errors++; $display("FAIL color_visible: got 0x%0h want 0x7", color); end
    wait_pos(469, 2);
    checks++; if (color !== 4'h7) begin errors++; $display("FAIL color_last_pixel: got 0x%0h want 0x7", color); end
    wait_pos(470, 2);
    checks++; if (color !== 4'h0) begin errors++; $display("FAIL color_hblank: got 0x%0h want 0x0", color); end
    wait_pos(100, TB_VA);
    checks++; if (color !== 4'h0) begin errors++; $display("FAIL color_vblank: got 0x%0h want 0x0", color); end
  endtask

  task automatic test_frame_flag();
    logic [7:0] seen;
    int irq_hi, n;
    bus_read(1'b1, seen);  // clear any flag left from earlier frames
    cpu_mode = 1'b1;
    wait_pos(0, TB_VA);
    checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL flag_before_set: got 0x%02h want 0x00", cpu_dout); end
    irq_hi = 0;
    n = 0;
    while (vsync !== 1'b0 && n < TB_VT * H_TOT) begin
      tick(1); n++;
      if (irq !== 1'b0) irq_hi++;
    end
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL vsync_wait: vsync=%b after %0d clocks, want 0", vsync, n); end
    bus_read(1'b1, seen);
    checks++; if (seen !== 8'h80) begin errors++; $display("FAIL status_first: got 0x%02h want 0x80", seen); end
    if (irq !== 1'b0) irq_hi++;
    bus_read(1'b1, seen);
    checks++; if (seen !== 8'h00) begin errors++; $display("FAIL status_second: got 0x%02h want 0x00", seen); end
    if (irq !== 1'b0) irq_hi++;
    checks++; if (irq_hi !== 0) begin errors++; $display("FAIL irq_masked: irq high %0d samples, want 0", irq_hi); end
  endtask

  task automatic test_irq();
    logic [7:0] seen;
    bus_write(1'b1, 8'h20, 3);
    bus_write(1'b1, 8'h81, 3);
    wait_pos(0, TB_VA);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_frame: got %b want 0", irq); end
    tick(2);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end
    cpu_mode = 1'b1;
    cpu_rd   = 1'b1;
    tick(3);
    checks++; if (cpu_dout !== 8'h80) begin errors++; $display("FAIL irq_status: got 0x%02h want 0x80", cpu_dout); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_during_read: got %b want 1", irq); end
    cpu_rd = 1'b0;
    tick(2);
    $display("[tb] read  stat (irq ack)");
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_ack: got %b want 0", irq); end
    // Masking IE drops irq without touching F
    wait_pos(3, TB_VA);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_reassert: got %b want 1", irq); end
    bus_write(1'b1, 8'h00, 3);
    bus_write(1'b1, 8'h81, 3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked_off: got %b want 0", irq); end
    bus_read(1'b1, seen);
    checks++; if (seen !== 8'h80) begin errors++; $display("FAIL flag_kept: got 0x%02h want 0x80", seen); end
  endtask

  task automatic test_address();
    logic [7:0] seen;
    bus_write(1'b1, 8'h34, 3);
    bus_write(1'b1, 8'h52, 3);
    checks++; if (dut.addr_reg !== 14'h1234) begin errors++; $display("FAIL addr_setup: got 0x%04h want 0x1234", dut.addr_reg); end
    checks++; if (dut.write_mode_reg !== 1'b1) begin errors++; $display("FAIL write_mode: got %b want 1", dut.write_mode_reg); end
    bus_write(1'b0, 8'hA5, 3);
    bus_write(1'b0, 8'h5A, 3);
    checks++; if (dut.addr_reg !== 14'h1236) begin errors++; $display("FAIL addr_incr: got 0x%04h want 0x1236", dut.addr_reg); end
    bus_write(1'b0, 8'h11, 10);  // long strobe must still count once
    checks++; if (dut.addr_reg !== 14'h1237) begin errors++; $display("FAIL addr_hold: got 0x%04h want 0x1237", dut.addr_reg); end
    bus_write(1'b1, 8'hFF, 3);
    bus_write(1'b1, 8'h7F, 3);
    checks++; if (dut.addr_reg !== 14'h3FFF) begin errors++; $display("FAIL addr_top: got 0x%04h want 0x3FFF", dut.addr_reg); end
    bus_write(1'b0, 8'h00, 3);
    checks++; if (dut.addr_reg !== 14'h0000) begin errors++; $display("FAIL addr_wrap: got 0x%04h want 0x0000", dut.addr_reg); end
    bus_write(1'b1, 8'h00, 3);
    bus_write(1'b1, 8'h10, 3);
    checks++; if (dut.addr_reg !== 14'h1001) begin errors++; $display("FAIL addr_read_setup: got 0x%04h want 0x1001", dut.addr_reg); end
    checks++; if (dut.write_mode_reg !== 1'b0) begin errors++; $display("FAIL read_mode: got %b want 0", dut.write_mode_reg); end
    bus_read(1'b0, seen);
    checks++; if (seen !== 8'h00) begin errors++; $display("FAIL data_read: got 0x%02h want 0x00", seen); end
    checks++; if (dut.addr_reg !== 14'h1002) begin errors++; $display("FAIL addr_after_read: got 0x%04h want 0x1002", dut.addr_reg); end
  endtask

  task automatic test_latch_clear();
    logic [7:0] seen;
    bus_write(1'b1, 8'h55, 3);
    checks++; if (dut.latch_flag_reg !== 1'b1) begin errors++; $display("FAIL latch_set: got %b want 1", dut.latch_flag_reg); end
    bus_read(1'b1, seen);
    checks++; if (dut.latch_flag_reg !== 1'b0) begin errors++; $display("FAIL latch_status_clear: got %b want 0", dut.latch_flag_reg); end
    bus_write(1'b1, 8'h0C, 3);
    bus_write(1'b1, 8'h87, 3);
    checks++; if (dut.vreg[7] !== 8'h0C) begin errors++; $display("FAIL latch_resync: R7 got 0x%02h want 0x0C", dut.vreg[7]); end
    bus_write(1'b1, 8'h11, 3);
    bus_write(1'b0, 8'h22, 3);
    checks++; if (dut.latch_flag_reg !== 1'b0) begin errors++; $display("FAIL latch_data_clear: got %b want 0", dut.latch_flag_reg); end
  endtask

  task automatic test_timing();
    int n, low;
    n = 0;
    while (hsync !== 1'b0 && n < 2 * H_TOT) begin tick(1); n++; end
    low = 0;
    n = 0;
    while (hsync === 1'b0 && n < 2 * H_TOT) begin tick(1); n++; end
    low = n;
    while (hsync !== 1'b0 && n < 4 * H_TOT) begin tick(1); n++; end
    $display("[tb] hsync low %0d clocks, period %0d clocks", low, n);
    checks++; if (low !== 70)    begin errors++; $display("FAIL hsync_width: got %0d want 70", low); end
    checks++; if (n !== H_TOT)   begin errors++; $display("FAIL hsync_period: got %0d want %0d", n, H_TOT); end
    n = 0;
    while (vsync !== 1'b0 && n < 2 * TB_VT * H_TOT) begin tick(1); n++; end
    n = 0;
    while (vsync === 1'b0 && n < 2 * TB_VT * H_TOT) begin tick(1); n++; end
    low = n;
    while (vsync !== 1'b0 && n < 4 * TB_VT * H_TOT) begin tick(1); n++; end
    $display("[tb] vsync low %0d clocks, period %0d clocks", low, n);
    checks++; if (low !== TB_VS * H_TOT) begin errors++; $display("FAIL vsync_width: got %0d want %0d", low, TB_VS * H_TOT); end
    checks++; if (n !== TB_VT * H_TOT)   begin errors++; $display("FAIL vsync_period: got %0d want %0d", n, TB_VT * H_TOT); end
  endtask

  task automatic test_reset_mid();
    bus_write(1'b1, 8'h99, 3);
    checks++; if (dut.latch_flag_reg !== 1'b1) begin errors++; $display("FAIL mid_latch_set: got %b want 1", dut.latch_flag_reg); end
    reset = 1'b0;
    tick(1);
    $display("[tb] reset during control sequence");
    checks++; if (dut.latch_flag_reg !== 1'b0) begin errors++; $display("FAIL mid_reset_latch: got %b want 0", dut.latch_flag_reg); end
    checks++; if (dut.vreg[7] !== 8'h00) begin errors++; $display("FAIL mid_reset_R7: got 0x%02h want 0x00", dut.vreg[7]); end
    reset = 1'b1;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_registers();
    test_frame_flag();
    test_irq();
    test_address();
    test_latch_clear();
    test_timing();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
